// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART (8N1) boot loader writing a counted little-endian word stream into instruction memory.
// Optional LOADER_CHECKSUM_EN: expect a trailing XOR checksum byte and verify it before DONE.
module uart_imem_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MEM_WORDS    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_a,
    output logic [31:0] imem_wd,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    typedef enum logic [2:0] {
        WAIT_COUNT,
        WAIT_DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } ld_state_t;

    logic            rx_s1, rx_s2, rx_d;
    rx_state_t       rx_state, rx_state_next;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic            rx_tick, byte_stb, frame_err;

    ld_state_t       state, state_next;
    logic [7:0]      word_cnt, word_idx;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_word;
    logic            count_ok, last_word;
    logic [31:0]     imem_a_q, imem_wd_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      chk_xor;
`endif

    // rx_d is the previous synchronized sample, used only for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_tick   = (rx_state == R_START) ? (bit_cnt == HALF_LAST) : (bit_cnt == FULL_LAST);
    assign byte_stb  = (rx_state == R_STOP) && rx_tick && rx_s2;
    assign frame_err = (rx_state == R_STOP) && rx_tick && !rx_s2;

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_d && !rx_s2) rx_state_next = R_START;
            R_START: if (rx_tick) rx_state_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && bit_idx == 3'd7) rx_state_next = R_STOP;
            R_STOP:  if (rx_tick) rx_state_next = R_IDLE;
            default: rx_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            if (rx_state == R_IDLE || rx_tick) bit_cnt <= '0;
            else                               bit_cnt <= bit_cnt + CW'(1);
            if (rx_state == R_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
        end
    end

    assign count_ok  = (rx_shift != 8'd0) && ({24'd0, rx_shift} <= MEM_WORDS);
    assign last_word = (word_idx + 8'd1) == word_cnt;

    always_comb begin
        state_next = state;
        case (state)
            WAIT_COUNT: begin
                if (frame_err)     state_next = ERROR;
                else if (byte_stb) state_next = count_ok ? WAIT_DATA : ERROR;
            end
            WAIT_DATA: begin
                if (frame_err)                          state_next = ERROR;
                else if (byte_stb && byte_idx == 2'd3)  state_next = WRITE;
            end
`ifdef LOADER_CHECKSUM_EN
            WRITE: state_next = last_word ? CHECK : WAIT_DATA;
            CHECK: begin
                if (frame_err)     state_next = ERROR;
                else if (byte_stb) state_next = (rx_shift == chk_xor) ? DONE : ERROR;
            end
`else
            WRITE: state_next = last_word ? DONE : WAIT_DATA;
`endif
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_COUNT;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            imem_a_q  <= '0;
            imem_wd_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_xor   <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                WAIT_COUNT: if (byte_stb && count_ok) begin
                    word_cnt <= rx_shift;
                    word_idx <= '0;
                    byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_xor  <= '0;
`endif
                end
                WAIT_DATA: if (byte_stb) begin
                    byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_xor  <= chk_xor ^ rx_shift;
`endif
                    // address/data registers load only here, so they hold between writes
                    case (byte_idx)
                        2'd0: asm_word[7:0]   <= rx_shift;
                        2'd1: asm_word[15:8]  <= rx_shift;
                        2'd2: asm_word[23:16] <= rx_shift;
                        default: begin
                            imem_a_q  <= {22'd0, word_idx, 2'b00};
                            imem_wd_q <= {rx_shift, asm_word};
                        end
                    endcase
                end
                WRITE:   word_idx <= word_idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_we   = (state == WRITE);
        load_done = (state == DONE);
        load_err  = (state == ERROR);
        load_busy = (state != DONE);
    end

    assign imem_a  = imem_a_q;
    assign imem_wd = imem_wd_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - randomized scoreboard bench for uart_imem_loader.
module tb_uart_imem_loader;

    localparam int CPB = 10;
    localparam int MW  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_a, imem_wd;
    logic        load_busy, load_done, load_err;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] wd;
    } wr_t;

    int          n_tests = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    logic [31:0] last_a = 0;
    logic [31:0] last_wd = 0;
    logic [7:0]  stim[$];
    int          bad_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a  = 0;
            last_wd = 0;
        end else if (imem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got a=0x%08h wd=0x%08h expected no write", imem_a, imem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_a", imem_a, e.a);
                chk("imem_wd", imem_wd, e.wd);
                last_a  = e.a;
                last_wd = e.wd;
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            ticks(CPB);
        end
        rx = stop;
        ticks(CPB);
        rx = 1'b1;
        ticks(2 * CPB);
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_a", imem_a, 32'd0);
        chk("rst_imem_wd", imem_wd, 32'd0);
        chk("rst_load_busy", {31'd0, load_busy}, 32'd1);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(3);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
    endtask

    task automatic add_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        for (int i = 1; i < stim.size(); i++) x ^= stim[i];
        stim.push_back(x);
`endif
    endtask

    // Reference model: decide outcome from the byte list, queue writes, then drive the line
    task automatic play();
        logic exp_done = 1'b0;
        logic exp_err = 1'b0;
        int   n = int'(stim[0]);
        if (bad_idx == 0 || n == 0 || n > MW) begin
            exp_err = 1'b1;
        end else begin
            logic [7:0] x = 8'd0;
            logic       stopped = 1'b0;
            for (int w = 0; w < n && !stopped; w++) begin
                logic [31:0] word = 32'd0;
                for (int b = 0; b < 4 && !stopped; b++) begin
                    int idx = 1 + 4 * w + b;
                    if (idx == bad_idx) stopped = 1'b1;
                    else begin
                        word = word | (32'(stim[idx]) << (8 * b));
                        x    = x ^ stim[idx];
                    end
                end
                if (!stopped) exp_q.push_back('{a: 32'(w * 4), wd: word});
            end
`ifdef LOADER_CHECKSUM_EN
            if (!stopped) begin
                if (bad_idx == 1 + 4 * n || stim[1 + 4 * n] != x) stopped = 1'b1;
            end
`endif
            exp_err  = stopped;
            exp_done = !stopped;
        end
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], i != bad_idx);
        ticks(3 * CPB);
        @(negedge clk);
        chk("load_done", {31'd0, load_done}, {31'd0, exp_done});
        chk("load_err", {31'd0, load_err}, {31'd0, exp_err});
        chk("load_busy", {31'd0, load_busy}, {31'd0, !exp_done});
        chk("pending_writes", exp_q.size(), 32'd0);
        chk("imem_a_hold", imem_a, last_a);
        chk("imem_wd_hold", imem_wd, last_wd);
        exp_q.delete();
    endtask

    initial begin
        bad_idx = -1;

        // single-word load
        do_reset();
        stim = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
        add_checksum();
        bad_idx = -1;
        play();

        // three-word program
        do_reset();
        stim = '{8'h03};
        push_word(32'h00500093);
        push_word(32'h00100113);
        push_word(32'h002081B3);
        add_checksum();
        play();

        // count out of range and count zero
        do_reset();
        stim = '{8'h15};
        play();
        do_reset();
        stim = '{8'(MW + 1), 8'h11, 8'h22};
        play();
        do_reset();
        stim = '{8'h00, 8'h11};
        play();

        // framing error on 2nd data byte, trailing bytes must be ignored
        do_reset();
        stim = '{8'h02};
        push_word(32'hA5A5_1234);
        push_word(32'h0BAD_F00D);
        bad_idx = 2;
        play();
        bad_idx = -1;

        // 0.3-bit glitch: no byte, loader still awaiting the count
        do_reset();
        rx = 1'b0;
        ticks(3 * CPB / 10);
        rx = 1'b1;
        ticks(3 * CPB);
        @(negedge clk);
        chk("glitch_busy", {31'd0, load_busy}, 32'd1);
        chk("glitch_err", {31'd0, load_err}, 32'd0);
        stim = '{8'h01};
        push_word(32'hCAFE_0042);
        add_checksum();
        play();

        // reset after 5 bytes aborts; next byte is a count again
        do_reset();
        exp_q.push_back('{a: 32'h0, wd: 32'h4433_2211});
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("midload_write_seen", exp_q.size(), 32'd0);
        rst_n = 1'b0;
        ticks(2);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        ticks(2);
        stim = '{8'h01};
        push_word(32'h1357_9BDF);
        add_checksum();
        play();

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        stim = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        play();
        do_reset();
        stim = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        play();
`endif

        // randomized loads: valid/invalid counts, random framing errors, bytes after DONE
        for (int it = 0; it < 14; it++) begin
            int n;
            do_reset();
            n = ($urandom % 5 == 0) ? int'($urandom_range(0, 1)) * (MW + 1 + int'($urandom_range(0, 3)))
                                    : int'($urandom_range(1, MW));
            stim = '{8'(n)};
            if (n >= 1 && n <= MW) begin
                for (int w = 0; w < n; w++) push_word($urandom);
                add_checksum();
`ifdef LOADER_CHECKSUM_EN
                if ($urandom % 4 == 0) stim[stim.size() - 1] ^= 8'(1 << $urandom_range(0, 7));
`endif
            end else begin
                stim.push_back(8'($urandom));
            end
            if ($urandom % 2 == 0) stim.push_back(8'($urandom));
            bad_idx = ($urandom % 4 == 0) ? int'($urandom_range(0, stim.size() - 1)) : -1;
            play();
        end
        bad_idx = -1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, SHALL set the CLK cycles per UART bit (10 MHz / 115200).
REQ-002 Parameter MEM_WORDS, default 20, SHALL set the maximum number of words loadable into instruction memory.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 RX  input  1  SHALL carry the asynchronous UART serial input (8N1, idle high).
REQ-006 IMEM_WE  output  1  SHALL be the instruction-memory write enable.
REQ-007 IMEM_A  output  32  SHALL be the instruction-memory byte address.
REQ-008 IMEM_WD  output  32  SHALL be the instruction-memory write data.
REQ-009 LOAD_BUSY  output  1  SHALL hold the core in reset while high.
REQ-010 LOAD_DONE  output  1  SHALL indicate a complete, valid program load.
REQ-011 LOAD_ERR  output  1  SHALL indicate a sticky load error.

Function
REQ-012 RX SHALL pass through a 2-flop synchronizer reset to 1 before any use.
REQ-013 The UART receiver SHALL detect the start bit on a synchronized high-to-low transition and sample at CLKS_PER_BIT/2 into it.
  - If RX is high at that sample: false start, return to idle, no byte.
  - Data bits sampled every CLKS_PER_BIT after that, LSB first; then the stop bit.
  - Stop bit = 1: one-cycle internal byte strobe. Stop bit = 0: framing error.
REQ-014 Loader FSM states SHALL be WAIT_COUNT, WAIT_DATA, WRITE, CHECK (macro only), DONE, ERROR.
REQ-015 WAIT_COUNT: the first byte SHALL be the word count N.
  - N in 1..MEM_WORDS: latch N, clear word index and byte index, go to WAIT_DATA.
  - N = 0 or N > MEM_WORDS: go to ERROR.
REQ-016 WAIT_DATA SHALL assemble bytes little-endian (byte 0 -> WD[7:0] ... byte 3 -> WD[31:24]) using a 2-bit byte index.
REQ-017 On the 4th byte strobe, the FSM SHALL enter WRITE on the next edge.
  - IMEM_WE is high for exactly one cycle.
  - IMEM_A = word_index*4 (upper bits zero); IMEM_WD = the assembled word.
REQ-018 After WRITE, word_index SHALL increment. If it equals N, go to DONE (or CHECK when enabled); otherwise return to WAIT_DATA.
REQ-019 IMEM_A and IMEM_WD SHALL hold their last values when IMEM_WE is low.
REQ-020 DONE: LOAD_DONE=1 and LOAD_BUSY=0; further RX bytes SHALL be ignored until reset.
REQ-021 A framing error in any state except DONE SHALL force ERROR.
REQ-022 ERROR: LOAD_ERR=1, LOAD_BUSY=1, LOAD_DONE=0, no writes; sticky until RST_N.
REQ-023 A byte strobe and a write cycle SHALL never coincide; this is guaranteed because WRITE lasts 1 cycle and a byte lasts 10*CLKS_PER_BIT cycles.

Reset
REQ-024 While RST_N is low, outputs SHALL be: IMEM_WE=0, IMEM_A=0, IMEM_WD=0, LOAD_BUSY=1, LOAD_DONE=0, LOAD_ERR=0.
REQ-025 While RST_N is low, FSM=WAIT_COUNT, receiver idle, and all counters zero.
REQ-026 Reset asserted mid-load SHALL abort immediately. Words already written stay in memory, and the load restarts at WAIT_COUNT.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined, one checksum byte SHALL follow the last data byte, and CHECK SHALL compare it to the XOR of all 4N data bytes.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
REQ-028 Without LOADER_CHECKSUM_EN, no checksum byte SHALL be expected, the CHECK state and XOR register SHALL be absent, and the FSM SHALL go straight to DONE.

Verification
REQ-029 Send 0x01, then bytes 13 00 00 00 -> one IMEM_WE pulse with A=0x00000000, WD=0x00000013; then LOAD_DONE=1, LOAD_BUSY=0.
REQ-030 Send N=0x03, then words 0x00500093, 0x00100113, 0x002081B3 -> three pulses at A=0x0, 0x4, 0x8 carrying those words in order.
REQ-031 Send count 0x15 (21) -> no writes; LOAD_ERR=1; LOAD_BUSY stays 1.
REQ-032 Send the 2nd data byte with stop bit 0 -> LOAD_ERR=1; no IMEM_WE for that word; sticky until RST_N.
REQ-033 Issue a 0.3-bit low glitch on RX -> no byte accepted; FSM unchanged. Separately, drop RST_N after 5 bytes -> outputs return to reset values, and the next byte is taken as the count.
REQ-034 LOADER_CHECKSUM_EN build: N=1, data 78 56 34 12, checksum 0x08 -> LOAD_DONE=1. The same load with checksum 0x09 -> LOAD_ERR=1.
